// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch generator.
// Optional statistics counters are enabled by defining IFU_PF_STATS_EN.
package ifu_pkg;

  localparam int INSTR_W    = 32;
  localparam int BURST_W    = 128;
  localparam int LINE_BYTES = 16;
  localparam int MAX_INS    = 4;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } ifu_state_e;

  // Start of the following 16-byte line; wraps modulo 2^32.
  function automatic logic [31:0] next_line(input logic [31:0] pc);
    return {pc[31:4] + 28'd1, 4'b0000};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/ifu_prefetch_gen_if.sv
// Line-fetch memory bus: single request channel plus a response channel without backpressure.
interface ifu_prefetch_gen_if;
  import ifu_pkg::*;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [31:0]        mem_req_addr;
  logic               mem_rsp_valid;
  logic [BURST_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/ifu_burst_align.sv
// Drops the instructions before the fetch offset and packs the rest into the low lanes.
module ifu_burst_align
  import ifu_pkg::*;
(
  input  logic               en,
  input  logic [BURST_W-1:0] line,
  input  logic [1:0]         offset,
  output logic [BURST_W-1:0] data,
  output logic [2:0]         count
);

  generate
    for (genvar gi = 0; gi < MAX_INS; gi++) begin : g_lane
      logic [2:0] src;
      assign src = 3'(gi) + {1'b0, offset};
      assign data[gi*INSTR_W +: INSTR_W] = (en && src < 3'(MAX_INS))
                                         ? line[src[1:0]*INSTR_W +: INSTR_W]
                                         : '0;
    end
  endgenerate

  assign count = en ? 3'(MAX_INS) - {1'b0, offset} : 3'd0;

endmodule

// File: rtl/ifu_prefetch_gen.sv
// Instruction prefetch generator: fetches 16-byte lines and writes aligned bursts to the FIFO.
// Define IFU_PF_STATS_EN to add saturating burst / full-stall / flush counters.
module ifu_prefetch_gen
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [31:0]        redirect_pc,
  input  logic               fifo_full,
  ifu_prefetch_gen_if.master mem,
  output logic               write_enable,
  output logic [BURST_W-1:0] write_data,
  output logic [31:0]        write_pc,
  output logic [2:0]         ins_count
`ifdef IFU_PF_STATS_EN
  ,
  output logic [31:0]        stat_bursts,
  output logic [31:0]        stat_full_stalls,
  output logic [31:0]        stat_flushes
`endif
);

  ifu_state_e         state_reg;
  logic [31:0]        fetch_pc_reg;
  logic [BURST_W-1:0] line_reg;
  logic               hold_st;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign hold_st             = (state_reg == ST_HOLD);

  assign mem.mem_req_valid = (state_reg == ST_REQ) && !rst;
  assign mem.mem_req_addr  = {fetch_pc_reg[31:4], 4'b0000};
  assign write_enable      = hold_st && !fifo_full && !flush && !rst;
  assign write_pc          = fetch_pc_reg;

  ifu_burst_align u_align (
    .en     (hold_st),
    .line   (line_reg),
    .offset (fetch_pc_reg[3:2]),
    .data   (write_data),
    .count  (ins_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_REQ;
      fetch_pc_reg <= RESET_PC;
      line_reg     <= '0;
    end else if (flush) begin
      // An accepted request or an in-flight line is left to be drained; the redirect wins.
      fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      unique case (state_reg)
        ST_REQ:  state_reg <= mem.mem_req_ready ? ST_DRAIN : ST_REQ;
        ST_WAIT: state_reg <= mem.mem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_HOLD: state_reg <= ST_REQ;
        default: state_reg <= mem.mem_rsp_valid ? ST_REQ : ST_DRAIN;
      endcase
    end else begin
      unique case (state_reg)
        ST_REQ: begin
          if (mem.mem_req_ready) state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.mem_rsp_valid) begin
            line_reg  <= mem.mem_rsp_data;
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!fifo_full) begin
            fetch_pc_reg <= next_line(fetch_pc_reg);
            state_reg    <= ST_REQ;
          end
        end
        default: begin
          if (mem.mem_rsp_valid) state_reg <= ST_REQ;
        end
      endcase
    end
  end

`ifdef IFU_PF_STATS_EN
  logic [31:0] bursts_reg;
  logic [31:0] full_stalls_reg;
  logic [31:0] flushes_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      bursts_reg      <= '0;
      full_stalls_reg <= '0;
      flushes_reg     <= '0;
    end else begin
      if (write_enable)         bursts_reg      <= sat_inc(bursts_reg);
      if (hold_st && fifo_full) full_stalls_reg <= sat_inc(full_stalls_reg);
      if (flush)                flushes_reg     <= sat_inc(flushes_reg);
    end
  end

  assign stat_bursts      = bursts_reg;
  assign stat_full_stalls = full_stalls_reg;
  assign stat_flushes     = flushes_reg;
`endif

endmodule

// File: doc/ifu_prefetch_gen.md
IFU_PREFETCH_GEN -- requirements
Module: ifu_prefetch_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch PC loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port flush  input  1  SHALL be the EX-stage mispredict redirect strobe.
REQ-005 Port redirect_pc  input  32  SHALL be the new fetch PC, valid when flush=1.
REQ-006 Port fifo_full  input  1  SHALL be the instruction FIFO "no room for a 4-instruction burst" flag.
REQ-007 Port mem_req_valid  output  1  SHALL mark a valid line-fetch request.
REQ-008 Port mem_req_ready  input  1  SHALL mark request acceptance by memory.
REQ-009 Port mem_req_addr  output  32  SHALL be the 16-byte-aligned line address, bits [3:0]=0.
REQ-010 Port mem_rsp_valid  input  1  SHALL mark return of the 128-bit line; no backpressure.
REQ-011 Port mem_rsp_data  input  128  SHALL be the line, word 0 in [31:0].
REQ-012 Port write_enable  output  1  SHALL be the burst write strobe to the FIFO.
REQ-013 Port write_data  output  128  SHALL be the burst, first valid instruction in [31:0].
REQ-014 Port write_pc  output  32  SHALL be the PC of the instruction in write_data[31:0].
REQ-015 Port ins_count  output  3  SHALL be the number of valid instructions in the burst (1-4).

Function
REQ-016 The block SHALL implement states REQ, WAIT, HOLD, DRAIN, with at most one request outstanding.
REQ-017 In REQ, mem_req_valid=1 and mem_req_addr={fetch_pc[31:4],4'b0}; on mem_req_ready, go to WAIT.
REQ-018 In WAIT, on mem_rsp_valid, capture mem_rsp_data and go to HOLD.
REQ-019 In HOLD, write_enable SHALL equal !fifo_full && !flush, combinationally.
REQ-020 HOLD SHALL persist while fifo_full=1, with the burst held stable.
REQ-021 When a write occurs, fetch_pc SHALL become {fetch_pc[31:4]+1,4'b0} and the state SHALL go to REQ.
REQ-022 ins_count SHALL equal 4-fetch_pc[3:2].
REQ-023 write_data SHALL equal the captured line right-shifted by 32*fetch_pc[3:2] bits, with upper lanes zero.
REQ-024 write_pc SHALL equal fetch_pc, including its [3:2] offset.
REQ-025 Minimum latency SHALL be one cycle from mem_rsp_valid to write_enable.
REQ-026 flush SHALL have priority over all other events: fetch_pc<=redirect_pc, and write_enable is suppressed that cycle.
REQ-027 On flush, the next state SHALL be as follows: REQ->REQ; HOLD->REQ; WAIT->DRAIN; WAIT with mem_rsp_valid in the same cycle->REQ (response discarded).
REQ-028 In DRAIN, the next mem_rsp_valid SHALL be discarded and the state SHALL go to REQ; a flush in DRAIN only updates fetch_pc.
REQ-029 In REQ, mem_req_addr SHALL change while mem_req_valid=1 and unaccepted only on flush.
REQ-030 A flush coincident with mem_req_ready in REQ SHALL count as accepted, and the state SHALL go to DRAIN.
REQ-031 fetch_pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFF0+16 wraps to 0.
REQ-032 redirect_pc[1:0] SHALL be ignored (treated as 0).

Reset
REQ-033 rst=1 SHALL set the state to REQ, fetch_pc=RESET_PC, and the capture register to 0.
REQ-034 Outputs SHALL be write_enable=0, ins_count=0, write_data=0, and write_pc=RESET_PC during and after reset until HOLD.
REQ-035 mem_req_valid SHALL be 0 while rst=1 and 1 on the first cycle after reset.
REQ-036 Reset SHALL override flush; an outstanding memory response after mid-operation reset is the memory's responsibility to cancel.

Configuration
REQ-037 With IFU_PF_STATS_EN defined, the block SHALL add outputs stat_bursts[31:0] (writes), stat_full_stalls[31:0] (HOLD cycles with fifo_full=1), and stat_flushes[31:0]; all counters are reset to 0 and saturate at 32'hFFFF_FFFF.
REQ-038 Without IFU_PF_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-039 Package ifu_pkg SHALL hold the state enum, INSTR_W=32, BURST_W=128, LINE_BYTES=16, and MAX_INS=4.
REQ-040 The lane shift and ins_count logic SHALL live in the sub-module ifu_burst_align (combinational).

Verification
REQ-041 Reset with RESET_PC=0x100, ready=1, rsp after 2 cycles -> mem_req_addr=0x100, write_pc=0x100, ins_count=4; next mem_req_addr=0x110.
REQ-042 flush with redirect_pc=0x208 -> mem_req_addr=0x200, ins_count=2, write_data[63:0]=line[127:64], write_pc=0x208.
REQ-043 fifo_full=1 for 5 cycles while in HOLD -> write_enable=0 and burst stable for those cycles; one write on the first cycle with fifo_full=0.
REQ-044 flush in WAIT, then rsp_valid -> no write for that response; new request issued at redirect_pc in the next cycle.
REQ-045 flush coincident with mem_rsp_valid, and flush coincident with mem_req_ready -> no stale write_enable; state after each transition per REQ-027/REQ-030.
REQ-046 Wrap-around: fetch_pc=0xFFFF_FFF0 -> after the write, mem_req_addr=0x0000_0000.
